// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract engine: DIGIT bits per clock through a chain of full-adder cells,
// with a registered carry between digits. Optional flags via DIGIT_SERIAL_ADDER_FLAGS_EN.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] d;
    logic [WIDTH-1:0] acc_next;
    logic             finish;

    // One full-adder cell per bit of the digit; carry ripples within the digit only.
    assign c[0] = cy;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a  (op_a[i]),
            .b  (op_b[i]),
            .ci (c[i]),
            .s  (d[i]),
            .co (c[i+1])
        );
    end

    // New digit enters at the top while older digits drift toward the LSB.
    assign acc_next = (acc >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));
    assign finish   = (state == RUN) && (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        cy    <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a <= op_a >> DIGIT;
                    op_b <= op_b >> DIGIT;
                    cy   <= c[DIGIT];
                    acc  <= acc_next;
                    cnt  <= cnt + 1'b1;
                    if (finish) begin
                        sum   <= acc_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    // Operand sign bits are kept aside because op_a/op_b are consumed by shifting.
    logic sign_a, sign_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            sign_a <= a[WIDTH-1];
            sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (finish) begin
            carry    <= c[DIGIT];
            overflow <= (sign_a ~^ sign_b) & (acc_next[WIDTH-1] ^ sign_a);
            zero     <= (acc_next == '0);
        end
    end
`else
    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed + randomized bench for digit_serial_adder (WIDTH=32, DIGIT=4) against an
// arithmetic reference model; flag expectations follow DIGIT_SERIAL_ADDER_FLAGS_EN.
module tb_digit_serial_adder;
    localparam int W = 32;
    localparam int D = 4;
    localparam int N = W / D;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] sum;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        res_t   r;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint sr = s ? (sx - sy) : (sx + sy);
        r.sum   = s ? (x - y) : (x + y);
        r.carry = s ? (x >= y) : ((longint'(x) + longint'(y)) >= (64'sd1 <<< W));
        r.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero  = (r.sum == '0);
`ifndef DIGIT_SERIAL_ADDER_FLAGS_EN
        r.carry = 1'b0;
        r.ovf   = 1'b0;
        r.zero  = 1'b0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t exp);
        check({tag, "_sum"},   sum,            exp.sum);
        check({tag, "_carry"}, W'(carry),      W'(exp.carry));
        check({tag, "_ovf"},   W'(overflow),   W'(exp.ovf));
        check({tag, "_zero"},  W'(zero),       W'(exp.zero));
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until done, checking sum holds its old value meanwhile.
    task automatic wait_done(input string tag, input logic [W-1:0] hold, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            check({tag, "_hold"}, sum, hold);
        end
        check({tag, "_latency"}, W'(lat), W'(N + 1));
    endtask

    initial begin
        int           lat;
        res_t         r, r1, r2;
        logic [W-1:0] x, y;
        logic         s;

        // Reset state
        #2;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_sum",  sum,      '0);
        @(negedge clk) rst_n = 1'b1;

        // Simple add
        r = model(32'h5, 32'h3, 1'b0);
        issue(32'h5, 32'h3, 1'b0);
        check("add_busy", W'(busy), W'(1));
        wait_done("add", '0, lat);
        check_res("add", r);
        check("add_busy_done", W'(busy), '0);
        @(negedge clk);
        check("add_done_pulse", W'(done), '0);

        // Asynchronous reset mid-operation
        issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy),     '0);
        check("arst_done", W'(done),     '0);
        check("arst_sum",  sum,          '0);
        check("arst_carry", W'(carry),   '0);
        check("arst_ovf",  W'(overflow), '0);
        check("arst_zero", W'(zero),     '0);
        @(negedge clk) rst_n = 1'b1;

        // Wrap with carry-out
        r = model(32'hFFFF_FFFF, 32'h1, 1'b0);
        issue(32'hFFFF_FFFF, 32'h1, 1'b0);
        wait_done("wrap", '0, lat);
        check_res("wrap", r);

        // Subtract with signed overflow
        r1 = model(32'h8000_0000, 32'h1, 1'b1);
        issue(32'h8000_0000, 32'h1, 1'b1);
        wait_done("subov", r.sum, lat);
        check_res("subov", r1);

        // Handshake: start held through RUN with changing operands, then back-to-back in DONE
        r2 = model(32'h0000_1000, 32'h0000_2001, 1'b1);
        @(negedge clk);
        a = 32'h0000_1000; b = 32'h0000_2001; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= N; i++) begin
            #1 a = $urandom; b = $urandom; sub = 1'($urandom);
            @(negedge clk);
            check("hs_hold1", sum, r1.sum);
            check("hs_nodone", W'(done), '0);
        end
        @(negedge clk);
        check("hs_done1", W'(done), W'(1));
        check_res("hs_op1", r2);
        x = $urandom; y = $urandom; s = 1'($urandom);
        r = model(x, y, s);
        a = x; b = y; sub = s;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("hs_b2b", r2.sum, lat);
        check_res("hs_op2", r);
        r1 = r;

        // Randomized operations
        for (int k = 0; k < 12; k++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            if (k == 0) y = x;
            r = model(x, y, s);
            issue(x, y, s);
            wait_done("rnd", r1.sum, lat);
            check_res("rnd", r);
            r1 = r;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
